alu_64bit: RTL and testbench
============================

Name: alu_64bit

Overview:
64-bit integer ALU for the datapath execute stage. Performs arithmetic, logic, shift and compare on two 64-bit operands selected by a 4-bit control code. Result and flags are registered: one clock of latency, qualified by a valid strobe.

Parameters:
WIDTH, 64, operand/result width in bits; shift amount uses the low log2(WIDTH) bits of b.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and alu_ctrl valid this cycle
a  input  64  operand A
b  input  64  operand B / shift amount source
alu_ctrl  input  4  operation select
out_valid  output  1  result/flags valid; registered copy of in_valid
result  output  64  registered operation result
zero  output  1  registered flag, 1 when result == 0
carry  output  1  registered carry-out (ADD) / no-borrow (SUB); 0 for other ops
overflow  output  1  registered signed overflow (ADD/SUB); 0 for other ops

Behaviour:
- Reset (rst_n low, asynchronous): result=0, zero=0, carry=0, overflow=0, out_valid=0 immediately; held while rst_n low.
- Latency 1: on each rising clk with rst_n high, out_valid <= in_valid. When in_valid=1, capture result/flags of the current a, b, alu_ctrl. When in_valid=0, result/zero/carry/overflow hold previous values.
- No backpressure; a new operation may be issued every cycle (full throughput).
- alu_ctrl decode:
  - 0000 ADD: a+b mod 2^64; carry = bit 64 of the sum.
  - 0001 SUB: a-b mod 2^64; carry = 1 when a >= b unsigned.
  - 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLL: a << b[5:0].
  - 0110 SRL: a >> b[5:0], zero fill.
  - 0111 SRA: a >>> b[5:0], sign fill from a[63].
  - 1000 SLT: 1 if signed(a) < signed(b), else 0 (zero-extended).
  - 1001 SLTU: 1 if unsigned a < unsigned b, else 0.
  - 1010 NOR: ~(a|b).
  - 1011 PASS_B: result = b.
  - 1100–1111 reserved: result = 0 (zero=1), carry=0, overflow=0.
- overflow: ADD sets when a[63]==b[63] and sum[63]!=a[63]; SUB sets when a[63]!=b[63] and diff[63]!=a[63].
- zero is computed from the final 64-bit result for every op, including compares and reserved codes.
- Shift amount b[63:6] ignored; shift by 0 returns a unchanged.
- No internal state beyond the output registers; in_valid deasserted mid-stream only gates update.

Test Plan:
- Reset: rst_n=0 mid-run with out_valid=1 -> all outputs 0 without waiting for clk; release, then first in_valid op appears the next edge.
- ADD a=0x10, b=0x3 -> result=0x13, zero=0, carry=0; a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, zero=1, carry=1; a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> overflow=1.
- SUB a=5, b=5 -> result=0, zero=1, carry=1; a=0, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF, carry=0.
- AND a=0xF0F0F0F0_F0F0F0F0, b=0x0F0F0F0F_0F0F0F0F -> result=0, zero=1; OR a=0xAAAAAAAA_AAAAAAAA, b=0x55555555_55555555 -> result=0xFFFFFFFF_FFFFFFFF, zero=0.
- SLL a=1, b=0x10 -> result=0x0000_0000_0001_0000; SRA a=0x8000_0000_0000_0000, b=1 -> 0xC000_0000_0000_0000; SRL same operands -> 0x4000_0000_0000_0000; b=0x41 shifts by 1.
- SLT a=-1, b=1 -> 1; SLTU same operands -> 0, zero=1; back-to-back ops each cycle -> results emerge one per cycle in order; in_valid=0 -> outputs hold, out_valid=0.

Source files
------------

// File: rtl/alu_64bit.sv
// Registered 64-bit integer ALU: arithmetic, logic, shift and compare with
// one cycle of latency; result and flags update only on in_valid.
module alu_64bit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_AND    = 4'b0010,
    OP_OR     = 4'b0011,
    OP_XOR    = 4'b0100,
    OP_SLL    = 4'b0101,
    OP_SRL    = 4'b0110,
    OP_SRA    = 4'b0111,
    OP_SLT    = 4'b1000,
    OP_SLTU   = 4'b1001,
    OP_NOR    = 4'b1010,
    OP_PASS_B = 4'b1011
  } op_e;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;
  logic             slt;
  logic             sltu;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the borrow; carry reports no-borrow.
    diff  = {1'b0, a} - {1'b0, b};
    shamt = b[SHW-1:0];
    slt   = $signed(a) < $signed(b);
    sltu  = a < b;
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op_e'(alu_ctrl))
      OP_ADD: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff[WIDTH-1:0];
        carry_d = ~diff[WIDTH];
        ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:    res_d = a & b;
      OP_OR:     res_d = a | b;
      OP_XOR:    res_d = a ^ b;
      OP_SLL:    res_d = a << shamt;
      OP_SRL:    res_d = a >> shamt;
      OP_SRA:    res_d = WIDTH'($signed(a) >>> shamt);
      OP_SLT:    res_d = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU:   res_d = {{(WIDTH-1){1'b0}}, sltu};
      OP_NOR:    res_d = ~(a | b);
      OP_PASS_B: res_d = b;
      default:   res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= res_d;
        zero     <= (res_d == '0);
        carry    <= carry_d;
        overflow <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_64bit.sv
// Self-checking bench for alu_64bit: directed vector table, hand-written
// reset/hold sequences and randomized traffic against a behavioural model.
module tb_alu_64bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [3:0]  alu_ctrl = '0;
  logic        out_valid;
  logic [63:0] result;
  logic        zero;
  logic        carry;
  logic        overflow;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  alu_64bit #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .alu_ctrl(alu_ctrl), .out_valid(out_valid), .result(result),
    .zero(zero), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic        z;
    logic        c;
    logic        o;
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        z;
    logic        c;
    logic        o;
  } vec_t;

  // Overflow is judged by whether the exact integer result fits in 64 signed bits.
  function automatic res_t model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    res_t m;
    logic [64:0] wide;
    logic signed [65:0] exact;
    logic [5:0] sh;
    m.r = '0; m.c = 1'b0; m.o = 1'b0;
    sh = y[5:0];
    case (op)
      4'd0: begin
        wide  = {1'b0, x} + {1'b0, y};
        m.r   = wide[63:0];
        m.c   = wide[64];
        exact = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
        m.o   = exact != $signed({{2{m.r[63]}}, m.r});
      end
      4'd1: begin
        m.r   = x - y;
        m.c   = x >= y;
        exact = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
        m.o   = exact != $signed({{2{m.r[63]}}, m.r});
      end
      4'd2: m.r = x & y;
      4'd3: m.r = x | y;
      4'd4: m.r = x ^ y;
      4'd5: m.r = x << sh;
      4'd6: m.r = x >> sh;
      4'd7: m.r = (x >> sh) | (x[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> sh) : 64'd0);
      4'd8: m.r = {63'd0, $signed(x) < $signed(y)};
      4'd9: m.r = {63'd0, x < y};
      4'd10: m.r = ~(x | y);
      4'd11: m.r = y;
      default: m.r = '0;
    endcase
    m.z = (m.r == 64'd0);
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input res_t e);
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, v});
    chk({tag, ".result"},    result, e.r);
    chk({tag, ".zero"},      {63'd0, zero}, {63'd0, e.z});
    chk({tag, ".carry"},     {63'd0, carry}, {63'd0, e.c});
    chk({tag, ".overflow"},  {63'd0, overflow}, {63'd0, e.o});
  endtask

  vec_t vecs[$];
  res_t exp_s;
  res_t rst_s;
  logic exp_v;

  initial begin
    rst_s = '{r: 64'd0, z: 1'b0, c: 1'b0, o: 1'b0};

    vecs.push_back('{4'd0,  64'h10, 64'h3, 64'h13, 0, 0, 0});
    vecs.push_back('{4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1, 1, 0});
    vecs.push_back('{4'd0,  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 0, 0, 1});
    vecs.push_back('{4'd1,  64'h5, 64'h5, 64'h0, 1, 1, 0});
    vecs.push_back('{4'd1,  64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0});
    vecs.push_back('{4'd1,  64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 1});
    vecs.push_back('{4'd2,  64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1, 0, 0});
    vecs.push_back('{4'd3,  64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0});
    vecs.push_back('{4'd4,  64'h1234_0000_0000_00FF, 64'h1234_0000_0000_00FF, 64'h0, 1, 0, 0});
    vecs.push_back('{4'd5,  64'h1, 64'h10, 64'h0000_0000_0001_0000, 0, 0, 0});
    vecs.push_back('{4'd7,  64'h8000_0000_0000_0000, 64'h1, 64'hC000_0000_0000_0000, 0, 0, 0});
    vecs.push_back('{4'd6,  64'h8000_0000_0000_0000, 64'h1, 64'h4000_0000_0000_0000, 0, 0, 0});
    vecs.push_back('{4'd6,  64'h8000_0000_0000_0000, 64'h41, 64'h4000_0000_0000_0000, 0, 0, 0});
    vecs.push_back('{4'd5,  64'h1234, 64'h40, 64'h1234, 0, 0, 0});
    vecs.push_back('{4'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 0, 0, 0});
    vecs.push_back('{4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1, 0, 0});
    vecs.push_back('{4'd10, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0});
    vecs.push_back('{4'd11, 64'h5, 64'hDEAD, 64'hDEAD, 0, 0, 0});
    vecs.push_back('{4'd12, 64'h1, 64'h1, 64'h0, 1, 0, 0});
    vecs.push_back('{4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1, 0, 0});

    // Initial asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1 chk_all("reset0", 1'b0, rst_s);
    #10 rst_n = 1'b1;

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = 1'b1;
      alu_ctrl = vecs[i].op;
      a = vecs[i].a;
      b = vecs[i].b;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), 1'b1,
              '{r: vecs[i].r, z: vecs[i].z, c: vecs[i].c, o: vecs[i].o});
    end

    // Hold: new operands with in_valid low must not disturb the outputs.
    exp_s = '{r: vecs[vecs.size()-1].r, z: vecs[vecs.size()-1].z,
              c: vecs[vecs.size()-1].c, o: vecs[vecs.size()-1].o};
    in_valid = 1'b0;
    alu_ctrl = 4'd0;
    a = 64'h7FFF_FFFF_FFFF_FFFF;
    b = 64'h1;
    @(posedge clk); #1;
    chk_all("hold", 1'b0, exp_s);

    // Randomized back-to-back traffic with interleaved idle cycles.
    exp_v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      alu_ctrl = 4'($urandom_range(0, 15));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = {1'b0, {63{1'b1}}};
        2: b = {1'b1, 63'd0};
        3: b = 64'($urandom_range(0, 130));
        default: ;
      endcase
      @(posedge clk);
      exp_v = in_valid;
      if (in_valid) exp_s = model(alu_ctrl, a, b);
      #1 chk_all($sformatf("rand%0d", i), exp_v, exp_s);
    end

    // Mid-run reset while a result is valid, away from any clock edge.
    in_valid = 1'b1;
    alu_ctrl = 4'd3;
    a = 64'h00FF;
    b = 64'hFF00;
    @(posedge clk); #1;
    chk_all("pre_rst", 1'b1, model(4'd3, 64'h00FF, 64'hFF00));
    #2 rst_n = 1'b0;
    #1 chk_all("midrst", 1'b0, rst_s);
    @(negedge clk);
    rst_n = 1'b1;
    alu_ctrl = 4'd0;
    a = 64'hFFFF_FFFF_FFFF_FFFF;
    b = 64'h2;
    @(posedge clk); #1;
    chk_all("post_rst", 1'b1, '{r: 64'h1, z: 1'b0, c: 1'b1, o: 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
